// File: rtl/alt_vipitc131_genlock_controller_if.sv
// Configuration bus between the control slave and the genlock controller:
// requested SOF position/divider plus the pending flag read back by software.
interface alt_vipitc131_genlock_controller_if;
    logic        cfg_wr;
    logic [13:0] cfg_sof_sample;
    logic [12:0] cfg_sof_line;
    logic [1:0]  cfg_sof_subsample;
    logic [13:0] cfg_divider;
    logic        cfg_pending;

    modport master (
        output cfg_wr, cfg_sof_sample, cfg_sof_line, cfg_sof_subsample, cfg_divider,
        input  cfg_pending
    );
    modport slave (
        input  cfg_wr, cfg_sof_sample, cfg_sof_line, cfg_sof_subsample, cfg_divider,
        output cfg_pending
    );
endinterface

// File: rtl/alt_vipitc131_genlock_controller.sv
// Genlock sequencer: gates the sync generator, applies shadowed SOF/divider config at
// frame boundaries and qualifies lock by sof/vid_sof matching. Optional: GENLOCK_CTRL_LOSS_COUNTER_EN.
module alt_vipitc131_genlock_controller #(
    parameter int LOCK_FRAMES   = 3,
    parameter int UNLOCK_FRAMES = 2,
    parameter int SOF_WINDOW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        genlock_en,
    input  logic        stable,
    input  logic        sof_locked,
    input  logic        sof,
    input  logic        vid_sof,
    alt_vipitc131_genlock_controller_if.slave cfg,
    output logic        output_enable,
    output logic        clear_enable,
    output logic [13:0] sof_sample,
    output logic [12:0] sof_line,
    output logic [1:0]  sof_subsample,
    output logic [13:0] divider_value,
    output logic        locked,
    output logic [2:0]  state,
    output logic [7:0]  loss_count
);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_FRAMES);
    localparam logic [7:0] WIN_N    = 8'(SOF_WINDOW);

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        ARM      = 3'd1,
        ACQUIRE  = 3'd2,
        LOCKED   = 3'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  match_cnt_reg, match_cnt_next;
    logic [3:0]  miss_cnt_reg, miss_cnt_next;
    logic        win_open_reg, win_open_next;
    logic        win_src_reg, win_src_next;   // 1: window opened by vid_sof
    logic [7:0]  win_cnt_reg, win_cnt_next;
    logic        win_other, win_opener;
    logic        match_ev, miss_ev, apply;
    logic        cfg_pending_reg;
    logic [13:0] pend_sample_reg, pend_divider_reg;
    logic [12:0] pend_line_reg;
    logic [1:0]  pend_subsample_reg;

    assign apply           = cfg_pending_reg && (sof || state_reg == DISABLED);
    assign cfg.cfg_pending = cfg_pending_reg;
    assign state           = state_reg;

    // Match window: the first of sof/vid_sof opens it, the other one must follow within SOF_WINDOW.
    always_comb begin
        match_ev      = 1'b0;
        miss_ev       = 1'b0;
        win_open_next = win_open_reg;
        win_src_next  = win_src_reg;
        win_cnt_next  = win_cnt_reg;
        win_other     = win_src_reg ? sof : vid_sof;
        win_opener    = win_src_reg ? vid_sof : sof;
        if (state_reg == ACQUIRE || state_reg == LOCKED) begin
            if (!win_open_reg) begin
                if (sof && vid_sof) begin
                    match_ev = 1'b1;
                end else if (sof || vid_sof) begin
                    win_open_next = 1'b1;
                    win_src_next  = vid_sof;
                    win_cnt_next  = 8'd0;
                end
            end else if (win_other && win_cnt_reg < WIN_N) begin
                match_ev      = 1'b1;
                win_open_next = 1'b0;
            end else if (win_opener) begin
                miss_ev      = 1'b1;
                win_cnt_next = 8'd0;
            end else if (win_cnt_reg >= WIN_N) begin
                miss_ev       = 1'b1;
                win_open_next = 1'b0;
            end else begin
                win_cnt_next = win_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        if (state_reg == ACQUIRE) begin
            if (match_ev)
                match_cnt_next = (match_cnt_reg == 4'hF) ? 4'hF : match_cnt_reg + 4'd1;
            else if (miss_ev)
                match_cnt_next = 4'd0;
        end
        if (state_reg == LOCKED) begin
            if (miss_ev)
                miss_cnt_next = (miss_cnt_reg == 4'hF) ? 4'hF : miss_cnt_reg + 4'd1;
            else if (match_ev)
                miss_cnt_next = 4'd0;
        end
        case (state_reg)
            DISABLED: state_next = ARM;
            ARM:      if (sof_locked) state_next = ACQUIRE;
            ACQUIRE: begin
                if (!sof_locked)
                    state_next = ARM;
                else if (match_cnt_next == LOCK_N)
                    state_next = LOCKED;
            end
            LOCKED: begin
                if (!sof_locked || miss_cnt_next == UNLOCK_N || apply)
                    state_next = ACQUIRE;
            end
            default: state_next = DISABLED;
        endcase
        if (!(genlock_en && stable))
            state_next = DISABLED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= DISABLED;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_enable      <= 1'b0;
            clear_enable       <= 1'b1;
            locked             <= 1'b0;
            match_cnt_reg      <= 4'd0;
            miss_cnt_reg       <= 4'd0;
            win_open_reg       <= 1'b0;
            win_src_reg        <= 1'b0;
            win_cnt_reg        <= 8'd0;
            cfg_pending_reg    <= 1'b0;
            pend_sample_reg    <= 14'd0;
            pend_line_reg      <= 13'd0;
            pend_subsample_reg <= 2'd0;
            pend_divider_reg   <= 14'd0;
            sof_sample         <= 14'd0;
            sof_line           <= 13'd0;
            sof_subsample      <= 2'd0;
            divider_value      <= 14'd0;
        end else begin
            // Outputs follow the next state so locked drops in the same cycle state leaves LOCKED.
            output_enable <= (state_next != DISABLED);
            clear_enable  <= (state_next == DISABLED) || (state_next == ARM && state_reg != ARM);
            locked        <= (state_next == LOCKED);
            if (state_next != state_reg) begin
                match_cnt_reg <= 4'd0;
                miss_cnt_reg  <= 4'd0;
                win_open_reg  <= 1'b0;
                win_cnt_reg   <= 8'd0;
            end else begin
                match_cnt_reg <= match_cnt_next;
                miss_cnt_reg  <= miss_cnt_next;
                win_open_reg  <= win_open_next;
                win_src_reg   <= win_src_next;
                win_cnt_reg   <= win_cnt_next;
            end
            if (apply) begin
                sof_sample    <= pend_sample_reg;
                sof_line      <= pend_line_reg;
                sof_subsample <= pend_subsample_reg;
                divider_value <= pend_divider_reg;
            end
            if (cfg.cfg_wr) begin
                cfg_pending_reg    <= 1'b1;
                pend_sample_reg    <= cfg.cfg_sof_sample;
                pend_line_reg      <= cfg.cfg_sof_line;
                pend_subsample_reg <= cfg.cfg_sof_subsample;
                pend_divider_reg   <= cfg.cfg_divider;
            end else if (apply) begin
                cfg_pending_reg <= 1'b0;
            end
        end
    end

`ifdef GENLOCK_CTRL_LOSS_COUNTER_EN
    logic       loss_ev;
    logic [7:0] loss_count_reg;

    assign loss_ev    = (state_reg == LOCKED) && (state_next == ACQUIRE) &&
                        (!sof_locked || miss_cnt_next == UNLOCK_N);
    assign loss_count = loss_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            loss_count_reg <= 8'd0;
        else if (state_next == DISABLED)
            loss_count_reg <= 8'd0;
        else if (loss_ev && loss_count_reg != 8'hFF)
            loss_count_reg <= loss_count_reg + 8'd1;
    end
`else
    assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_alt_vipitc131_genlock_controller.sv
// Directed bench for the genlock controller: lock acquisition/loss, match window,
// config shadowing and reset behaviour with default parameters (3/2/4).
module tb_alt_vipitc131_genlock_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        genlock_en = 1'b0;
    logic        stable = 1'b0;
    logic        sof_locked = 1'b0;
    logic        sof = 1'b0;
    logic        vid_sof = 1'b0;
    logic        output_enable, clear_enable, locked;
    logic [13:0] sof_sample, divider_value;
    logic [12:0] sof_line;
    logic [1:0]  sof_subsample;
    logic [2:0]  state;
    logic [7:0]  loss_count;
    int          checks = 0;
    int          failures = 0;

    alt_vipitc131_genlock_controller_if cfg_bus();

    alt_vipitc131_genlock_controller dut (
        .clk           (clk),
        .rst           (rst),
        .genlock_en    (genlock_en),
        .stable        (stable),
        .sof_locked    (sof_locked),
        .sof           (sof),
        .vid_sof       (vid_sof),
        .cfg           (cfg_bus.slave),
        .output_enable (output_enable),
        .clear_enable  (clear_enable),
        .sof_sample    (sof_sample),
        .sof_line      (sof_line),
        .sof_subsample (sof_subsample),
        .divider_value (divider_value),
        .locked        (locked),
        .state         (state),
        .loss_count    (loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic int exp_loss(input int n);
`ifdef GENLOCK_CTRL_LOSS_COUNTER_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: sof, then vid_sof 'gap' cycles later (0 = same cycle), then idle.
    task automatic frame(input int gap);
        if (gap == 0) begin
            sof = 1'b1; vid_sof = 1'b1; tick(); sof = 1'b0; vid_sof = 1'b0;
        end else begin
            sof = 1'b1; tick(); sof = 1'b0;
            if (gap > 1) tick(gap - 1);
            vid_sof = 1'b1; tick(); vid_sof = 1'b0;
        end
        tick(12);
    endtask

    task automatic cfg_write(input int line, input int sample, input int sub, input int div);
        cfg_bus.cfg_wr            = 1'b1;
        cfg_bus.cfg_sof_line      = 13'(line);
        cfg_bus.cfg_sof_sample    = 14'(sample);
        cfg_bus.cfg_sof_subsample = 2'(sub);
        cfg_bus.cfg_divider       = 14'(div);
    endtask

    task automatic lock_up();
        frame(2); frame(2); frame(2);
    endtask

    initial begin
        cfg_bus.cfg_wr = 1'b0;
        cfg_bus.cfg_sof_line = '0;
        cfg_bus.cfg_sof_sample = '0;
        cfg_bus.cfg_sof_subsample = '0;
        cfg_bus.cfg_divider = '0;
        tick(3);
        check("reset_state", state, 0);
        check("reset_oe", output_enable, 0);
        check("reset_clear", clear_enable, 1);
        check("reset_locked", locked, 0);
        check("reset_pending", cfg_bus.cfg_pending, 0);
        check("reset_loss", loss_count, 0);
        rst = 1'b0;
        tick();

        // Enable: ARM with a single-cycle clear pulse
        genlock_en = 1'b1; stable = 1'b1;
        tick();
        check("arm_state", state, 1);
        check("arm_oe", output_enable, 1);
        check("arm_clear_first", clear_enable, 1);
        tick();
        check("arm_clear_second", clear_enable, 0);
        sof_locked = 1'b1;
        tick();
        check("acquire_state", state, 2);

        frame(2); frame(2);
        check("two_matches_not_locked", locked, 0);
        frame(2);
        check("third_match_locked", locked, 1);
        check("third_match_state", state, 3);

        // vid_sof 6 cycles late: outside the 4-cycle window
        frame(6); frame(6);
        check("late_unlocked", locked, 0);
        check("late_state", state, 2);
        check("late_loss", loss_count, exp_loss(1));

        // Mid-frame config write while LOCKED, applied on the next sof
        lock_up();
        check("relock_state", state, 3);
        cfg_write(100, 0, 0, 0); tick(); cfg_bus.cfg_wr = 1'b0;
        check("cfg_pending_set", cfg_bus.cfg_pending, 1);
        check("cfg_line_held", sof_line, 0);
        tick(3);
        check("cfg_line_held_later", sof_line, 0);
        sof = 1'b1; tick(); sof = 1'b0;
        check("cfg_line_applied", sof_line, 100);
        check("cfg_pending_clear", cfg_bus.cfg_pending, 0);
        check("cfg_apply_state", state, 2);
        check("cfg_apply_no_loss", loss_count, exp_loss(1));
        tick(12);

        // Same-cycle sof/vid_sof counts as a match
        frame(0); frame(0);
        check("same_cycle_two", state, 2);
        frame(0);
        check("same_cycle_locked", state, 3);

        // Drop sof_locked: loss, back to ACQUIRE
        sof_locked = 1'b0; tick();
        check("sof_unlock_state", state, 2);
        check("sof_unlock_locked", locked, 0);
        check("sof_unlock_loss", loss_count, exp_loss(2));
        sof_locked = 1'b1; tick(2);

        // Repeated sof is a miss; the window reopens on the second sof
        frame(2); frame(2);
        sof = 1'b1; tick(); sof = 1'b0; tick();
        sof = 1'b1; tick(); sof = 1'b0; tick();
        vid_sof = 1'b1; tick(); vid_sof = 1'b0; tick(12);
        check("double_sof_not_locked", state, 2);
        frame(2);
        check("after_double_two", state, 2);
        frame(2);
        check("after_double_locked", state, 3);

        // stable drops in ACQUIRE with config pending
        sof_locked = 1'b0; tick(); sof_locked = 1'b1; tick();
        check("pre_drop_state", state, 2);
        check("pre_drop_loss", loss_count, exp_loss(3));
        cfg_write(55, 7, 2, 300); tick(); cfg_bus.cfg_wr = 1'b0;
        stable = 1'b0; tick();
        check("drop_state", state, 0);
        check("drop_oe", output_enable, 0);
        check("drop_clear", clear_enable, 1);
        check("drop_loss_cleared", loss_count, 0);
        check("drop_pending_still", cfg_bus.cfg_pending, 1);
        tick();
        check("drop_line", sof_line, 55);
        check("drop_sample", sof_sample, 7);
        check("drop_subsample", sof_subsample, 2);
        check("drop_divider", divider_value, 300);
        check("drop_pending_clear", cfg_bus.cfg_pending, 0);

        // In DISABLED: write while an apply happens keeps the new value pending
        cfg_write(11, 0, 0, 1); tick();
        cfg_write(22, 0, 0, 2); tick(); cfg_bus.cfg_wr = 1'b0;
        check("overlap_applied_first", sof_line, 11);
        check("overlap_still_pending", cfg_bus.cfg_pending, 1);
        tick();
        check("overlap_applied_second", sof_line, 22);
        check("overlap_divider", divider_value, 2);

        // Reset mid-LOCKED
        stable = 1'b1; tick(3);
        lock_up();
        check("pre_reset_locked", locked, 1);
        #2 rst = 1'b1;
        tick();
        check("rst_state", state, 0);
        check("rst_oe", output_enable, 0);
        check("rst_clear", clear_enable, 1);
        check("rst_locked", locked, 0);
        check("rst_line", sof_line, 0);
        check("rst_divider", divider_value, 0);
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
